// File: rtl/coin_pkg.sv
// Shared types and sprite geometry for the spinning-coin sequencer.
package coin_pkg;

  typedef enum logic [1:0] {
    SPIN   = 2'd0,
    POP    = 2'd1,
    HIDDEN = 2'd2
  } coin_state_t;

  localparam int SPRITE_W      = 20;
  localparam int SPRITE_H      = 20;
  localparam int SPRITE_PIXELS = SPRITE_W * SPRITE_H;
  localparam int COORD_W       = 11;
  localparam int ADDR_W        = $clog2(SPRITE_PIXELS);
  localparam int POP_OFF_W     = 8;

  // Row-major address into a 20x20 frame ROM; callers guarantee rx, ry < 20.
  function automatic logic [ADDR_W-1:0] pix_addr(input logic [4:0] rx,
                                                 input logic [4:0] ry);
    return ADDR_W'(ry) * ADDR_W'(SPRITE_W) + ADDR_W'(rx);
  endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Turns the asynchronous vsync level into a one-Clk-cycle tick.
// The tick is registered, so it is high in the 3rd cycle after frame_clk rises.
module frame_tick_gen (
  input  logic Clk,
  input  logic Reset,
  input  logic frame_clk,
  output logic tick
);

  logic sync1_q, sync2_q, edge_q, tick_q;
  logic tick_d;

  assign tick_d = sync2_q & ~edge_q;

  // Two-flop synchronizer, previous-level register and registered rising edge.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      edge_q  <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      sync1_q <= frame_clk;
      sync2_q <= sync1_q;
      edge_q  <= sync2_q;
      tick_q  <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/coin_anim_ctrl.sv
// Spinning-coin sequencer: spin-frame timing, collect/pop-up/respawn life
// cycle and the registered scan-position to frame-ROM address stage.
// Build option: define COIN_POP_EN to include the pop-up animation (POP state,
// pop counter and vertical offset). Without it, a collect hides the coin at
// once and the vertical offset is constant zero.
module coin_anim_ctrl
  import coin_pkg::*;
#(
  parameter int NUM_FRAMES      = 4,
  parameter int TICKS_PER_FRAME = 6,
  parameter int POP_STEPS       = 12,
  parameter int POP_DY          = 2
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  input  logic [9:0] coin_x,
  input  logic [9:0] coin_y,
  input  logic       collect,
  input  logic       respawn,
  output logic [8:0] rom_addr,
  output logic [1:0] frame_sel,
  output logic       is_coin,
  output logic       coin_active,
  output logic       score_pulse
);

  localparam int TICK_W = (TICKS_PER_FRAME > 1) ? $clog2(TICKS_PER_FRAME) : 1;

  // The pop offset must fit its 8-bit register and frame_sel is only 2 bits.
  generate
    if ((POP_STEPS * POP_DY > 255) || (NUM_FRAMES < 1) || (NUM_FRAMES > 4)) begin : g_bad_cfg
      $error("coin_anim_ctrl: unsupported parameter combination");
    end
  endgenerate

  coin_state_t           state_q, state_d;
  logic [1:0]            frame_q, frame_d;
  logic [TICK_W-1:0]     tick_cnt_q, tick_cnt_d;
  logic                  score_q, score_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic                  coin_q, coin_d;
  logic [POP_OFF_W-1:0]  pop_off;
  logic                  tick;

  logic                  spin_wrap;
  logic [TICK_W-1:0]     tick_cnt_spin;
  logic [1:0]            frame_spin;

  frame_tick_gen u_tick (
    .Clk       (Clk),
    .Reset     (Reset),
    .frame_clk (frame_clk),
    .tick      (tick)
  );

`ifdef COIN_POP_EN
  localparam int POP_W = (POP_STEPS > 1) ? $clog2(POP_STEPS + 1) : 1;

  logic [POP_W-1:0]     pop_cnt_q, pop_cnt_d;
  logic [POP_OFF_W-1:0] pop_off_q, pop_off_d;

  assign pop_off = pop_off_q;
`else
  assign pop_off = '0;
`endif

  // Spin advance applied on a tick: counter rolls over and bumps the frame.
  assign spin_wrap     = (tick_cnt_q == TICK_W'(TICKS_PER_FRAME - 1));
  assign tick_cnt_spin = spin_wrap ? '0 : tick_cnt_q + TICK_W'(1);
  assign frame_spin    = !spin_wrap ? frame_q :
                         (frame_q == 2'(NUM_FRAMES - 1)) ? 2'd0 : frame_q + 2'd1;

  // Next-state and counter logic; collect takes priority over a same-cycle tick.
  always_comb begin
    state_d    = state_q;
    frame_d    = frame_q;
    tick_cnt_d = tick_cnt_q;
    score_d    = 1'b0;
`ifdef COIN_POP_EN
    pop_cnt_d  = pop_cnt_q;
    pop_off_d  = pop_off_q;
`endif
    case (state_q)
      SPIN: begin
        if (collect) begin
          score_d    = 1'b1;
          tick_cnt_d = '0;
`ifdef COIN_POP_EN
          state_d    = POP;
          pop_cnt_d  = '0;
          pop_off_d  = '0;
`else
          state_d    = HIDDEN;
`endif
        end else if (tick) begin
          tick_cnt_d = tick_cnt_spin;
          frame_d    = frame_spin;
        end
      end
`ifdef COIN_POP_EN
      POP: begin
        if (tick) begin
          tick_cnt_d = tick_cnt_spin;
          frame_d    = frame_spin;
          pop_cnt_d  = pop_cnt_q + POP_W'(1);
          pop_off_d  = pop_off_q + POP_OFF_W'(POP_DY);
          if (pop_cnt_q == POP_W'(POP_STEPS - 1)) begin
            state_d = HIDDEN;
          end
        end
      end
`endif
      HIDDEN: begin
        if (respawn) begin
          state_d    = SPIN;
          frame_d    = '0;
          tick_cnt_d = '0;
`ifdef COIN_POP_EN
          pop_cnt_d  = '0;
          pop_off_d  = '0;
`endif
        end
      end
      default: begin
        state_d = SPIN;
      end
    endcase
  end

  // State, spin counters and the registered score pulse.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= SPIN;
      frame_q    <= '0;
      tick_cnt_q <= '0;
      score_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      frame_q    <= frame_d;
      tick_cnt_q <= tick_cnt_d;
      score_q    <= score_d;
    end
  end

`ifdef COIN_POP_EN
  // Pop-up progress and the upward pixel offset it produces.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pop_cnt_q <= '0;
      pop_off_q <= '0;
    end else begin
      pop_cnt_q <= pop_cnt_d;
      pop_off_q <= pop_off_d;
    end
  end
`endif

  // Scan position relative to the (possibly raised) sprite origin. Inputs
  // are zero-extended to 11 bits so a sprite raised above row 0 yields a
  // negative top and its rows clip instead of wrapping to the bottom.
  logic [COORD_W-1:0] top_y, rel_x, rel_y;
  logic               in_x, in_y;

  assign top_y = COORD_W'(coin_y) - COORD_W'(pop_off);
  assign rel_x = COORD_W'(DrawX) - COORD_W'(coin_x);
  assign rel_y = COORD_W'(DrawY) - top_y;
  assign in_x  = !rel_x[COORD_W-1] && (rel_x < COORD_W'(SPRITE_W));
  assign in_y  = !rel_y[COORD_W-1] && (rel_y < COORD_W'(SPRITE_H));

  // Window test and ROM address for the pixel currently being scanned.
  always_comb begin
    coin_d = in_x && in_y && (state_q != HIDDEN);
    addr_d = '0;
    if (coin_d) begin
      addr_d = pix_addr(rel_x[4:0], rel_y[4:0]);
    end
  end

  // One-cycle address stage so ROM data lines up with is_coin.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      addr_q <= '0;
      coin_q <= 1'b0;
    end else begin
      addr_q <= addr_d;
      coin_q <= coin_d;
    end
  end

  assign rom_addr    = addr_q;
  assign frame_sel   = frame_q;
  assign is_coin     = coin_q;
  assign coin_active = (state_q == SPIN);
  assign score_pulse = score_q;

endmodule

// File: doc/coin_anim_ctrl.md
# coin_anim_ctrl

Sequencer for the spinning-coin sprite: advances the spin frame on vertical-sync ticks, handles the collect/pop-up/respawn life cycle, and converts the VGA scan position into a 9-bit address for the 20x20 coin frame ROMs. It sits between the VGA controller and the coin frame ROMs. The color mapper uses `is_coin`, `frame_sel` and the ROM color output to draw the coin.

## Interface
Parameters:
- `NUM_FRAMES`, 4: spin frames; `frame_sel` wraps from 0 to NUM_FRAMES-1.
- `TICKS_PER_FRAME`, 6: vsync ticks per spin-frame advance.
- `POP_STEPS`, 12: vsync ticks spent in the pop-up animation.
- `POP_DY`, 2: pixels the coin rises per pop step.

Ports:
- `Clk` in 1: system clock.
- `Reset` in 1: asynchronous, active-high reset.
- `frame_clk` in 1: VGA vsync, level signal; its rising edge is one tick.
- `DrawX` in 10: current pixel column.
- `DrawY` in 10: current pixel row.
- `coin_x` in 10: sprite top-left column.
- `coin_y` in 10: sprite top-left row.
- `collect` in 1: Mario/coin overlap; level-sensitive, sampled each cycle.
- `respawn` in 1: request to re-show the coin.
- `rom_addr` out 9: ROM read address, rel_y*20+rel_x.
- `frame_sel` out 2: selects which frame ROM output the mapper uses.
- `is_coin` out 1: current pixel lies inside the visible sprite window.
- `coin_active` out 1: coin is collectible (SPIN state).
- `score_pulse` out 1: single-cycle pulse on collect.

## Operation
- Tick: rising edge of `frame_clk`, detected from a 2-flop synchronizer plus an edge register. `tick` is high for 1 Clk cycle.
- States: SPIN, POP, HIDDEN. Reset enters SPIN.
- SPIN:
  - `tick_cnt` counts ticks; at TICKS_PER_FRAME-1 it clears and `frame_sel` increments, wrapping NUM_FRAMES-1 to 0.
  - `collect`=1 goes to POP: `score_pulse`=1 for that cycle, `pop_cnt`=0, `pop_off`=0, `tick_cnt`=0.
- POP:
  - Each tick: `pop_cnt`++, `pop_off` += POP_DY. `frame_sel` keeps spinning at the normal rate.
  - Tick with `pop_cnt`=POP_STEPS-1 goes to HIDDEN.
- HIDDEN: `is_coin`=0. `respawn`=1 goes to SPIN with `frame_sel`=0, `tick_cnt`=0, `pop_off`=0.
- Ignored inputs:
  - `collect` outside SPIN.
  - `respawn` outside HIDDEN.
  - `collect` held high stays in POP and yields exactly one `score_pulse`.
- Simultaneous events: `collect` and `tick` in the same cycle means collect wins and the tick is discarded.
- Address arithmetic:
  - Coordinates are 11-bit signed: rel_x = DrawX - coin_x, rel_y = DrawY - (coin_y - pop_off).
  - Window is 0 <= rel_x < 20 and 0 <= rel_y < 20.
  - A negative top row (coin popped above the screen) clips those rows and never wraps.
  - Outside the window: `rom_addr`=0, `is_coin`=0.
  - `pop_off` width is 8 bits; POP_STEPS*POP_DY <= 255 is required.
- `coin_active` = (state==SPIN).

## Timing
- Reset values:
  - `rom_addr`=0, `frame_sel`=0, `is_coin`=0, `coin_active`=1 (SPIN), `score_pulse`=0.
  - `tick_cnt`, `pop_cnt`, `pop_off` = 0; synchronizer flops = 0.
- `rom_addr` and `is_coin` are registered, so they have 1 Clk latency from `DrawX`/`DrawY`. The ROM is combinational, so its color aligns with `is_coin` in the same cycle.
- `tick` occurs 3 Clk cycles after the `frame_clk` rise.
- `frame_sel`, state and `pop_off` update only on the clock edge where the tick or event is seen.
- `score_pulse` is registered and rises one cycle after `collect` is sampled in SPIN.
- Reset asserted mid-POP forces SPIN immediately; no `score_pulse` is emitted.

## Configuration
- `COIN_POP_EN` defined: POP state and `pop_cnt`/`pop_off` logic are present as above.
- `COIN_POP_EN` undefined: POP is removed. `collect` in SPIN goes directly to HIDDEN with the same `score_pulse`, and `pop_off` is constant 0.

## Structure
- Package `coin_pkg`:
  - `coin_state_t` enum {SPIN, POP, HIDDEN}.
  - `SPRITE_W`=20, `SPRITE_H`=20, `SPRITE_PIXELS`=400, `COORD_W`=11.
- Sub-module `frame_tick_gen`: synchronizer plus rising-edge detector, Clk/Reset/frame_clk in, `tick` out.
- Remaining logic is one module: state register, counters, and the registered address stage.

## Test plan
- Scan address: coin_x=100, coin_y=50, DrawX=105, DrawY=53 gives `rom_addr`=65 and `is_coin`=1 one cycle later. DrawX=120 gives `is_coin`=0, `rom_addr`=0.
- Frame wrap: TICKS_PER_FRAME=6, 24 vsync pulses in SPIN gives `frame_sel` sequence 0,1,2,3,0, advancing every 6th tick.
- Collect in SPIN: exactly one `score_pulse`; `coin_active` drops to 0. After 12 ticks the state is HIDDEN and `is_coin` stays 0 for all pixels.
- Pop clipping: coin_y=5, POP_DY=2, after 5 pop ticks `pop_off`=10. DrawY=0 maps to rel_y=5, giving `rom_addr`=100+rel_x.
- Simultaneous tick and collect: both asserted together gives POP with `pop_cnt`=0 and `frame_sel` unchanged. `collect` while HIDDEN gives no pulse. `respawn` in HIDDEN gives SPIN with `frame_sel`=0.
- Reset mid-POP: asynchronous Reset assertion gives SPIN with all outputs at reset values in the same cycle.
